// File: rtl/knapsack_input_loader.sv
// knapsack_input_loader
// Front end of the knapsack circuit. Debounces the confirm and release buttons, walks the
// operator through the field sequence N, W, w[0..ITEMS-1], p[0..ITEMS-1], latching each switch
// value into a register bank, and offers the finished problem to the solver with a
// valid/accept handshake.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   in_signal_c  raw confirm button (asynchronous, bouncy)
//   in_signal_r  raw release/commit button (asynchronous, bouncy)
//   sw           switch value, sampled only on a confirm pulse
//   n_val        committed N field
//   w_cap        committed capacity W
//   weights      committed w[i] at bits [i*DATA_W +: DATA_W]
//   prices       committed p[i], same packing
//   field_idx    index of the field being entered; FIELDS once the problem is complete
//   staged       value latched by the last confirm (display)
//   staged_vld   a confirmed value is waiting for commit
//   prob_valid   complete problem available to the solver
//   prob_accept  solver takes the problem
module knapsack_input_loader #(
  parameter int unsigned ITEMS           = 4,
  parameter int unsigned DATA_W          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 100,
  localparam int unsigned FIELDS         = 2 + 2 * ITEMS,
  localparam int unsigned IDX_W          = $clog2(FIELDS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_signal_c,
  input  logic                    in_signal_r,
  input  logic [DATA_W-1:0]       sw,
  output logic [DATA_W-1:0]       n_val,
  output logic [DATA_W-1:0]       w_cap,
  output logic [DATA_W*ITEMS-1:0] weights,
  output logic [DATA_W*ITEMS-1:0] prices,
  output logic [IDX_W-1:0]        field_idx,
  output logic [DATA_W-1:0]       staged,
  output logic                    staged_vld,
  output logic                    prob_valid,
  input  logic                    prob_accept
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  localparam logic [1:0] StEntry  = 2'd0;
  localparam logic [1:0] StStaged = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  // Button lanes: bit 0 = confirm, bit 1 = release.
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_deb;
  logic [1:0]       r_deb_q;
  logic [CNT_W-1:0] r_cnt [2];

  logic                    w_c_pulse;
  logic                    w_r_pulse;
  logic                    w_commit;
  logic [IDX_W-1:0]        w_idx_next;

  logic [1:0]              r_state;
  logic [IDX_W-1:0]        r_field_idx;
  logic [DATA_W-1:0]       r_staged;
  logic                    r_staged_vld;
  logic [DATA_W-1:0]       r_n_val;
  logic [DATA_W-1:0]       r_w_cap;
  logic [DATA_W*ITEMS-1:0] r_weights;
  logic [DATA_W*ITEMS-1:0] r_prices;

  // Synchroniser and debouncer. The counter only runs while the synchronised level disagrees
  // with the debounced one, so any bounce back to the old level restarts the stability window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      for (int b = 0; b < 2; b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      r_sync1 <= {in_signal_r, in_signal_c};
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_deb[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[b] <= r_sync2[b];
          r_cnt[b] <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + CNT_W'(1);
        end
      end
    end
  end

  assign w_c_pulse  = r_deb[0] & ~r_deb_q[0];
  assign w_r_pulse  = r_deb[1] & ~r_deb_q[1];
  // Release wins over a simultaneous confirm so the value the operator saw is the one stored.
  assign w_commit   = (r_state == StStaged) && w_r_pulse;
  assign w_idx_next = r_field_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StEntry;
      r_field_idx  <= '0;
      r_staged     <= '0;
      r_staged_vld <= 1'b0;
    end else begin
      case (r_state)
        StEntry: begin
          if (w_c_pulse) begin
            r_staged     <= sw;
            r_staged_vld <= 1'b1;
            r_state      <= StStaged;
          end
        end
        StStaged: begin
          if (w_commit) begin
            r_field_idx  <= w_idx_next;
            r_staged_vld <= 1'b0;
            r_state      <= (w_idx_next == IDX_W'(FIELDS)) ? StDone : StEntry;
          end else if (w_c_pulse) begin
            r_staged <= sw;
          end
        end
        StDone: begin
          if (prob_accept) begin
            r_field_idx <= '0;
            r_staged    <= '0;
            r_state     <= StEntry;
          end
        end
        default: r_state <= StEntry;
      endcase
    end
  end

  // Field bank: only the field addressed by field_idx is written on a commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n_val   <= '0;
      r_w_cap   <= '0;
      r_weights <= '0;
      r_prices  <= '0;
    end else if (w_commit) begin
      if (r_field_idx == IDX_W'(0)) r_n_val <= r_staged;
      if (r_field_idx == IDX_W'(1)) r_w_cap <= r_staged;
      for (int i = 0; i < ITEMS; i++) begin
        if (r_field_idx == IDX_W'(2 + i)) r_weights[i*DATA_W +: DATA_W] <= r_staged;
        if (r_field_idx == IDX_W'(2 + ITEMS + i)) r_prices[i*DATA_W +: DATA_W] <= r_staged;
      end
    end
  end

  assign n_val      = r_n_val;
  assign w_cap      = r_w_cap;
  assign weights    = r_weights;
  assign prices     = r_prices;
  assign field_idx  = r_field_idx;
  assign staged     = r_staged;
  assign staged_vld = r_staged_vld;
  assign prob_valid = (r_state == StDone);

endmodule
